veda_fetch_unit: RTL and testbench
==================================

// Module: veda_fetch_unit
// PURPOSE
//  Instruction fetch initiator for the VEDA core: owns the PC, issues word reads to the instruction
//  memory, buffers returned words in a small in-order queue and hands {pc, instr} to decode over a
//  valid/ready handshake. Accepts PC redirects (taken branch/jump) from execute and discards stale words.
// PARAMETERS
//  ADDR_W    5   word-address width of instruction memory (32 entries)
//  DATA_W    32  instruction width
//  BUF_DEPTH 2   instruction queue depth; also bounds outstanding reads (credit limit)
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       reset, synchronous, active-high
//  imem_req     out  1       read request, accepted every cycle it is high
//  imem_addr    out  ADDR_W  word address of request
//  imem_rvalid  in   1       read data valid; responses return in request order, latency >=1
//  imem_rdata   in   DATA_W  read data
//  redir_valid  in   1       redirect PC (taken branch/jump from execute)
//  redir_pc     in   ADDR_W  redirect target
//  out_valid    out  1       instruction available to decode
//  out_ready    in   1       decode accepts
//  out_instr    out  DATA_W  instruction word
//  out_pc       out  ADDR_W  address of out_instr
//  busy         out  1       high while DRAIN or any read outstanding
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=RUN, queue empty, outstanding=0; imem_req=0, out_valid=0, busy=0,
//    out_instr=0, out_pc=0. Reset mid-operation drops queue and in-flight reads; responses arriving
//    after reset released are discarded until outstanding counter (cleared) -- bench keeps memory idle.
//  - Issue rule (RUN): imem_req=1 iff outstanding + queue_count < BUF_DEPTH; imem_addr=pc; on issue
//    pc <= pc+1 modulo 2^ADDR_W (31 wraps to 0). Request tag pc pushed into an in-order addr FIFO.
//  - Response: imem_rvalid pushes {tag_pc, rdata} into queue, outstanding decrements. Credit rule
//    guarantees queue never overflows; an rvalid with outstanding==0 is ignored.
//  - Output: out_valid = queue non-empty (registered head, no comb path rdata->out). Pop on
//    out_valid && out_ready. Best case: one instruction per cycle sustained; first instr after reset
//    visible 2 cycles after request with 1-cycle memory.
//  - FSM: RUN -> DRAIN on redir_valid when outstanding>0 (after counting this cycle's rvalid);
//    RUN -> RUN on redir_valid when outstanding==0. DRAIN: imem_req=0, every rvalid discarded,
//    DRAIN -> RUN when outstanding reaches 0. redir_valid in DRAIN updates target only.
//  - Redirect cycle: queue flushed, pc <= redir_pc, out_valid=0 next cycle. Redirect beats a
//    simultaneous pop (pop still counts as consumed by decode) and a simultaneous rvalid (dropped).
//  - Counters: outstanding width $clog2(BUF_DEPTH+1); issue and return in same cycle leave it unchanged.
// CONFIGURATION
//  JUMP_PREDECODE_EN defined: word pushed into queue with opcode [31:26]==OP_JUMP (21) triggers an
//   internal redirect to instr[ADDR_W-1:0] (low bits of 26-bit target) the next cycle: younger
//   queued/in-flight words flushed/drained, the jump itself still delivered to decode.
//  Not defined: jumps are ordinary words; control changes only via redir_valid.
// STRUCTURE
//  veda_pkg: OP_JUMP=6'd21, OP_BEQ=6'd19, field slices (opcode/rs/rt/imm16/target26), fetch state enum.
//  Sub-module veda_fetch_fifo (parameterised {pc,instr} FIFO with flush) used for the queue.
// TESTING
//  1 Reset, memory holds i*3 at word i, 1-cycle latency, out_ready=1 -> out_pc 0,1,2.. one per
//    cycle, out_instr 0,3,6..; imem_req never exceeds 2 in flight.
//  2 out_ready=0 for 10 cycles -> after 2 words buffered imem_req=0; release -> pcs continue with no gap/dup.
//  3 pc reaches 31 -> next request addr 0, out_pc sequence ..30,31,0.
//  4 3-cycle latency, redir_valid pc=12 with 2 outstanding -> DRAIN, both stale words dropped,
//    first delivered out_pc=12, busy low exactly when drain completes.
//  5 Redirect same cycle as pop and rvalid -> popped word counted once, rvalid word never appears.
//  6 JUMP_PREDECODE_EN: word 5 = {6'd21,26'd2} -> decode sees pc 5 then pc 2, never pc 6;
//    without macro sees pc 6 next.

Source files
------------

// File: rtl/veda_pkg.sv
// Shared VEDA definitions: opcodes, instruction field helpers and the fetch FSM state type.
package veda_pkg;

  localparam logic [5:0] OP_JUMP = 6'd21;
  localparam logic [5:0] OP_BEQ  = 6'd19;

  typedef enum logic [0:0] {
    StRun,
    StDrain
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [15:0] imm16_of(input logic [31:0] instr);
    return instr[15:0];
  endfunction

  function automatic logic [25:0] target26_of(input logic [31:0] instr);
    return instr[25:0];
  endfunction

endpackage

// File: rtl/veda_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory read port, redirect input and decode handshake.
interface veda_fetch_unit_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              busy;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, busy,
    input  imem_rvalid, imem_rdata, redir_valid, redir_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, busy,
    output imem_rvalid, imem_rdata, redir_valid, redir_pc, out_ready
  );

endinterface

// File: rtl/veda_fetch_fifo.sv
// Small in-order FIFO with registered head and a flush that empties it in one cycle.
module veda_fetch_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A push into a full FIFO is legal only together with a pop; the caller guarantees it.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    do_pop = pop_i && (cnt_q != '0);
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/veda_fetch_unit.sv
// VEDA instruction fetch: PC, credit-limited imem reads, in-order queue to decode, redirect drain.
// Optional JUMP_PREDECODE_EN: a queued OP_JUMP word redirects fetch to its target on the next cycle.
module veda_fetch_unit
  import veda_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic            clk,
  input  logic            reset,
  veda_fetch_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CntW-1:0]   outst, outst_next, q_count;
  logic [ADDR_W-1:0] tag_head, redirect_pc;
  logic [EntW-1:0]   q_head;
  logic [SumW-1:0]   credit_used;
  logic              redirect, rsp_take, q_push, pop, issue;

`ifdef JUMP_PREDECODE_EN
  logic              jump_pend_q, jump_pend_d;
  logic [ADDR_W-1:0] jump_tgt_q, jump_tgt_d;

  always_comb begin
    jump_pend_d = q_push && (opcode_of(32'(bus.imem_rdata)) == OP_JUMP);
    jump_tgt_d  = ADDR_W'(target26_of(32'(bus.imem_rdata)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jump_pend_q <= 1'b0;
      jump_tgt_q  <= '0;
    end else begin
      jump_pend_q <= jump_pend_d;
      jump_tgt_q  <= jump_tgt_d;
    end
  end

  // The jump is the youngest queued word, so only in-flight reads need discarding.
  assign redirect    = bus.redir_valid | jump_pend_q;
  assign redirect_pc = bus.redir_valid ? bus.redir_pc : jump_tgt_q;
`else
  assign redirect    = bus.redir_valid;
  assign redirect_pc = bus.redir_pc;
`endif

  assign pop      = bus.out_valid & bus.out_ready;
  assign rsp_take = bus.imem_rvalid && (outst != '0);
  assign q_push   = rsp_take && (state_q == StRun) && !redirect;

  // A word leaving this cycle frees its slot, which keeps the one-per-cycle stream going.
  assign credit_used = SumW'(outst) + SumW'(q_count) - SumW'(pop);
  assign issue       = !reset && (state_q == StRun) && !redirect &&
                       (credit_used < SumW'(BUF_DEPTH));
  assign outst_next  = outst + CntW'(issue) - CntW'(rsp_take);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + ADDR_W'(1);
    end
    unique case (state_q)
      StRun:   if (redirect && (outst_next != '0)) state_d = StDrain;
      StDrain: if (outst_next == '0) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= ADDR_W'(RESET_PC);
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Request tags; its occupancy is the outstanding-read count.
  veda_fetch_fifo #(
    .WIDTH(ADDR_W),
    .DEPTH(BUF_DEPTH)
  ) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (issue),
    .push_data_i(pc_q),
    .pop_i      (rsp_take),
    .flush_i    (1'b0),
    .head_o     (tag_head),
    .count_o    (outst)
  );

  veda_fetch_fifo #(
    .WIDTH(EntW),
    .DEPTH(BUF_DEPTH)
  ) u_instr_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (q_push),
    .push_data_i({tag_head, bus.imem_rdata}),
    .pop_i      (pop),
    .flush_i    (bus.redir_valid),
    .head_o     (q_head),
    .count_o    (q_count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (q_count != '0);
  assign bus.out_pc    = q_head[EntW-1:DATA_W];
  assign bus.out_instr = q_head[DATA_W-1:0];
  assign bus.busy      = (state_q == StDrain) || (outst != '0);

endmodule

// File: tb/tb_veda_fetch_unit.sv
// Scoreboard bench for veda_fetch_unit: memory model with variable latency, directed scenarios.
module tb_veda_fetch_unit;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  veda_fetch_unit_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  veda_fetch_unit #(
    .ADDR_W   (5),
    .DATA_W   (32),
    .BUF_DEPTH(2),
    .RESET_PC (0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          req_count = 0;
  int          redir_cnt = 0;
  int          redir_done = 0;
  logic [4:0]  redir_tgt = '0;
  logic        ready_cfg = 1'b0;
  logic        arm5 = 1'b0;
  logic [31:0] mem [32];
  int          exp_q [$];
  rsp_t        rsp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_empty(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words still expected after %0d cycles, required 0",
               name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // Input driver and instruction memory model.
  initial begin
    rsp_t r;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;
    bus.out_ready   = 1'b0;
    forever begin
      @(negedge clk);
      bus.out_ready   = ready_cfg;
      bus.redir_valid = (redir_cnt != redir_done);
      bus.redir_pc    = redir_tgt;
      redir_done      = redir_cnt;
      if (reset) rsp_q.delete();
      if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
      #1;
      if (arm5 && bus.out_valid && bus.out_ready && bus.imem_rvalid) begin
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 5'd25;
        arm5            = 1'b0;
      end
      if (!reset && bus.imem_req) begin
        r.due  = cyc + lat;
        r.data = mem[bus.imem_addr];
        rsp_q.push_back(r);
        req_count++;
        checks++;
        if (rsp_q.size() > 2) begin
          errors++;
          $display("FAIL inflight: got %0d reads outstanding, expected at most 2", rsp_q.size());
        end
      end
    end
  end

  // Monitor: every accepted word is checked against the scoreboard.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deliver: got unexpected pc %0d instr %0h, expected no word",
                   bus.out_pc, bus.out_instr);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_pc !== 5'(e) || bus.out_instr !== mem[e]) begin
            errors++;
            $display("FAIL deliver: got pc %0d instr %0h, expected pc %0d instr %0h",
                     bus.out_pc, bus.out_instr, e, mem[e]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r1;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i * 3);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_out_pc", 32'(bus.out_pc), 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_imem_req", 32'(bus.imem_req), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: streaming with 1-cycle memory
    ready_cfg = 1'b1;
    for (int p = 0; p < 8; p++) exp_q.push_back(p);
    wait_empty("t1_stream", 60);
    ready_cfg = 1'b0;

    // 2: decode stall, queue fills and requests stop
    repeat (5) @(posedge clk);
    r1 = req_count;
    repeat (5) @(posedge clk);
    #1;
    chk("t2_req_stalled", 32'(req_count - r1), 0);
    chk("t2_buffered", 32'(bus.out_valid), 1);
    chk("t2_no_inflight", 32'(rsp_q.size()), 0);

    // 3: resume, continue through the 31 -> 0 wrap
    ready_cfg = 1'b1;
    for (int p = 8; p < 32; p++) exp_q.push_back(p);
    for (int p = 0; p < 3; p++) exp_q.push_back(p);
    wait_empty("t3_wrap", 100);
    ready_cfg = 1'b0;
    repeat (5) @(posedge clk);

    // 4: 3-cycle memory, redirect to 12 with two reads outstanding
    lat = 3;
    redir_tgt = 5'd20;
    redir_cnt++;
    repeat (3) @(posedge clk);
    redir_tgt = 5'd12;
    redir_cnt++;
    ready_cfg = 1'b1;
    for (int p = 12; p < 15; p++) exp_q.push_back(p);
    @(posedge clk);
    #1;
    chk("t4_busy_drain1", 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    chk("t4_busy_drain2", 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    chk("t4_busy_done", 32'(bus.busy), 0);
    wait_empty("t4_redirect", 100);
    ready_cfg = 1'b0;
    repeat (8) @(posedge clk);

    // 5: redirect coincides with a pop and a returning read
    lat = 1;
    arm5 = 1'b1;
    ready_cfg = 1'b1;
    exp_q.push_back(15);
    exp_q.push_back(16);
    exp_q.push_back(25);
    exp_q.push_back(26);
    exp_q.push_back(27);
    wait_empty("t5_collide", 60);
    ready_cfg = 1'b0;
    chk("t5_collision_hit", 32'(arm5), 0);
    repeat (5) @(posedge clk);

    // 6: jump word at pc 5
    mem[5] = {6'd21, 26'd2};
    redir_tgt = 5'd4;
    redir_cnt++;
    @(posedge clk);
    ready_cfg = 1'b1;
    exp_q.push_back(4);
    exp_q.push_back(5);
`ifdef JUMP_PREDECODE_EN
    exp_q.push_back(2);
    exp_q.push_back(3);
`else
    exp_q.push_back(6);
    exp_q.push_back(7);
`endif
    wait_empty("t6_jump", 60);
    ready_cfg = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("end_busy", 32'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
